// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard sequencer.
// Ports (slave = sequencer side):
//   in : if_id_rs1/rs2/use_rs2, id_ex_memread/rd, ex_mem_br_take, dmem_req, dmem_ready
//   out: pc_en, pc_sel_branch, en_* stage enables, flush_* stage flushes,
//        mem_err, stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_use_rs2;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic             ex_mem_br_take;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_sel_branch;
  logic             en_if_id;
  logic             en_id_ex;
  logic             en_ex_mem;
  logic             en_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_use_rs2, id_ex_memread, id_ex_rd,
           ex_mem_br_take, dmem_req, dmem_ready,
    input  pc_en, pc_sel_branch, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_use_rs2, id_ex_memread, id_ex_rd,
           ex_mem_br_take, dmem_req, dmem_ready,
    output pc_en, pc_sel_branch, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives PC/stage enables and bubbles for load-use
// hazards, taken-branch squashes and data-memory wait states; counts stalls and
// squashes; traps a hung data memory.
// Ports:
//   clk    - clock, rising edge
//   arst_n - synchronous active-low reset; forces every output to 0 while low
//   hz     - hazard-control bus (slave side), see pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TMO_W       = 7,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic load_use_c, mem_wait_c, eval_c;
  logic pc_en_c, pc_sel_c, en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
  logic fl_if_id_c, fl_id_ex_c, fl_ex_mem_c;

  // State register and counters
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Next state, counters and same-cycle control outputs
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_err_d   = mem_err_q;
    pc_en_c     = 1'b0;
    pc_sel_c    = 1'b0;
    en_if_id_c  = 1'b0;
    en_id_ex_c  = 1'b0;
    en_ex_mem_c = 1'b0;
    en_mem_wb_c = 1'b0;
    fl_if_id_c  = 1'b0;
    fl_id_ex_c  = 1'b0;
    fl_ex_mem_c = 1'b0;
    eval_c      = 1'b0;

    load_use_c = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                 ((hz.id_ex_rd == hz.if_id_rs1) ||
                  (hz.if_id_use_rs2 && (hz.id_ex_rd == hz.if_id_rs2)));
    mem_wait_c = hz.dmem_req && !hz.dmem_ready;

    case (state_q)
      ST_RUN: begin
        if (mem_wait_c) begin
          state_d = ST_WAIT;
          wcnt_d  = TMO_W'(1);
        end else begin
          eval_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (hz.dmem_ready) begin
          // Completing cycle resolves branch/load-use like a normal RUN cycle
          state_d = ST_RUN;
          wcnt_d  = '0;
          eval_c  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TMO_W'(1);
          if (wcnt_d == TMO_W'(MEM_TIMEOUT)) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ST_ERR:  mem_err_d = 1'b1;
      default: state_d = ST_RUN;
    endcase

    if (eval_c) begin
      if (hz.ex_mem_br_take) begin
        // Branch wins over load-use: squash the three younger stages
        pc_en_c     = 1'b1;
        pc_sel_c    = 1'b1;
        en_if_id_c  = 1'b1;
        en_id_ex_c  = 1'b1;
        en_ex_mem_c = 1'b1;
        en_mem_wb_c = 1'b1;
        fl_if_id_c  = 1'b1;
        fl_id_ex_c  = 1'b1;
        fl_ex_mem_c = 1'b1;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (load_use_c) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX
        en_id_ex_c  = 1'b1;
        fl_id_ex_c  = 1'b1;
        en_ex_mem_c = 1'b1;
        en_mem_wb_c = 1'b1;
      end else begin
        pc_en_c     = 1'b1;
        en_if_id_c  = 1'b1;
        en_id_ex_c  = 1'b1;
        en_ex_mem_c = 1'b1;
        en_mem_wb_c = 1'b1;
      end
    end

    if (!pc_en_c && (state_q != ST_ERR) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Outputs held at zero while reset is asserted
  assign hz.pc_en         = arst_n & pc_en_c;
  assign hz.pc_sel_branch = arst_n & pc_sel_c;
  assign hz.en_if_id      = arst_n & en_if_id_c;
  assign hz.en_id_ex      = arst_n & en_id_ex_c;
  assign hz.en_ex_mem     = arst_n & en_ex_mem_c;
  assign hz.en_mem_wb     = arst_n & en_mem_wb_c;
  assign hz.flush_if_id   = arst_n & fl_if_id_c;
  assign hz.flush_id_ex   = arst_n & fl_id_ex_c;
  assign hz.flush_ex_mem  = arst_n & fl_ex_mem_c;
  assign hz.mem_err       = arst_n & mem_err_q;
  assign hz.stall_cnt     = arst_n ? stall_cnt_q : '0;
  assign hz.flush_cnt     = arst_n ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TMO   = 4;
  localparam int unsigned TMO_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic arst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model state
  bit in_wait, trapped, m_err;
  int waits, m_stall, m_flush;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit mr, input int rd, input int rs1, input int rs2,
                       input bit u2, input bit br, input bit req, input bit rdy);
    hz.id_ex_memread  = mr;
    hz.id_ex_rd       = 5'(rd);
    hz.if_id_rs1      = 5'(rs1);
    hz.if_id_rs2      = 5'(rs2);
    hz.if_id_use_rs2  = u2;
    hz.ex_mem_br_take = br;
    hz.dmem_req       = req;
    hz.dmem_ready     = rdy;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance both.
  task automatic cyc();
    logic [8:0] exp_ctl, obs_ctl;
    bit lu, go;
    @(negedge clk);
    lu = hz.id_ex_memread && hz.id_ex_rd != 0 &&
         (hz.id_ex_rd == hz.if_id_rs1 || (hz.if_id_use_rs2 && hz.id_ex_rd == hz.if_id_rs2));
    if (trapped)      go = 0;
    else if (in_wait) go = hz.dmem_ready;
    else              go = !(hz.dmem_req && !hz.dmem_ready);
    // {pc_en, pc_sel, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, fl_if_id, fl_id_ex, fl_ex_mem}
    if (!arst_n || !go)        exp_ctl = 9'b0_0_0000_000;
    else if (hz.ex_mem_br_take) exp_ctl = 9'b1_1_1111_111;
    else if (lu)               exp_ctl = 9'b0_0_0111_010;
    else                       exp_ctl = 9'b1_0_1111_000;
    obs_ctl = {hz.pc_en, hz.pc_sel_branch, hz.en_if_id, hz.en_id_ex, hz.en_ex_mem,
               hz.en_mem_wb, hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem};
    chk("ctl", 32'(obs_ctl), 32'(exp_ctl));
    chk("stall_cnt", 32'(hz.stall_cnt), arst_n ? 32'(m_stall) : 32'd0);
    chk("flush_cnt", 32'(hz.flush_cnt), arst_n ? 32'(m_flush) : 32'd0);
    chk("mem_err", 32'(hz.mem_err), 32'(arst_n & m_err));
    @(posedge clk);
    if (!arst_n) begin
      in_wait = 0; trapped = 0; m_err = 0; waits = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!trapped && !exp_ctl[8] && m_stall < CMAX) m_stall++;
      if (go && hz.ex_mem_br_take && m_flush < CMAX) m_flush++;
      if (!trapped) begin
        if (in_wait) begin
          if (hz.dmem_ready) begin in_wait = 0; waits = 0; end
          else begin
            waits++;
            if (waits >= TMO) begin trapped = 1; m_err = 1; end
          end
        end else if (hz.dmem_req && !hz.dmem_ready) begin
          in_wait = 1; waits = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    in_wait = 0; trapped = 0; m_err = 0; waits = 0; m_stall = 0; m_flush = 0;
    // Reset with hazardous inputs: everything must read zero
    arst_n = 1'b0;
    drive(1, 5, 5, 5, 1, 1, 1, 0);
    cyc(); cyc();
    arst_n = 1'b1;

    // Load-use on rs1: one stall cycle, then free flow
    drive(1, 5, 5, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("t1_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // No hazard on x0, nor on rs2 when rs2 unused
    drive(1, 0, 0, 0, 1, 0, 0, 0); cyc();
    drive(1, 7, 1, 7, 0, 0, 0, 0); cyc();
    drive(1, 7, 1, 7, 1, 0, 0, 0); cyc();   // rs2 used: stalls
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("t2_stall_cnt", 32'(hz.stall_cnt), 32'd2);

    // Branch overrides a simultaneous load-use
    drive(1, 5, 5, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("t3_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    chk("t3_stall_cnt", 32'(hz.stall_cnt), 32'd2);

    // Three memory wait cycles then completion
    drive(0, 0, 0, 0, 0, 0, 1, 0); cyc(); cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1); cyc();
    chk("t4_pc_en_after", 32'(hz.pc_en), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("t4_stall_cnt", 32'(hz.stall_cnt), 32'd5);

    // Hung memory traps after TMO stalled cycles; only reset clears it
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("t5_mem_err", 32'(hz.mem_err), 32'd1);
    chk("t5_stall_cnt", 32'(hz.stall_cnt), 32'd9);
    arst_n = 1'b0; cyc();
    arst_n = 1'b1; cyc();
    chk("t5_err_cleared", 32'(hz.mem_err), 32'd0);

    // Stall counter saturation
    drive(1, 3, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("t6_stall_sat", 32'(hz.stall_cnt), 32'd15);
    drive(1, 3, 3, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("t6_flush_sat", 32'(hz.flush_cnt), 32'd15);

    // Random traffic with occasional resets
    arst_n = 1'b0; cyc(); arst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      arst_n = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
